// File: rtl/video_timing_pkg.sv
// video_timing_pkg: 640x480@60 VGA timing constants shared by the scanout blocks
package video_timing_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_ACTIVE = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END = VS_START + V_SYNC;
  localparam int Y0 = 40;
  localparam int PIC_LINES = 200;
  localparam int PIXEL_LATENCY = 3;
  typedef logic [9:0] cnt_t;
endpackage

// File: rtl/video_timing.sv
// video_timing: h/v counters plus raw visible/picture/sync flags and vblank pulse
// Ports: clk, reset (async, active-high); hcnt/vcnt counters; visible, picture,
// hsync_n/vsync_n (active-low, undelayed); vblank_irq at hcnt=0, vcnt=V_ACTIVE.
module video_timing #(
  parameter int H_ACTIVE = video_timing_pkg::H_ACTIVE,
  parameter int H_FP = video_timing_pkg::H_FP,
  parameter int H_SYNC = video_timing_pkg::H_SYNC,
  parameter int H_BP = video_timing_pkg::H_BP,
  parameter int V_ACTIVE = video_timing_pkg::V_ACTIVE,
  parameter int V_FP = video_timing_pkg::V_FP,
  parameter int V_SYNC = video_timing_pkg::V_SYNC,
  parameter int V_BP = video_timing_pkg::V_BP,
  parameter int Y0 = video_timing_pkg::Y0,
  parameter int PIC_LINES = video_timing_pkg::PIC_LINES
) (
  input  logic                   clk,
  input  logic                   reset,
  output video_timing_pkg::cnt_t hcnt,
  output video_timing_pkg::cnt_t vcnt,
  output logic                   visible,
  output logic                   picture,
  output logic                   hsync_n,
  output logic                   vsync_n,
  output logic                   vblank_irq
);
  import video_timing_pkg::*;
  localparam cnt_t H_LAST = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t V_LAST = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam cnt_t HA = cnt_t'(H_ACTIVE);
  localparam cnt_t VA = cnt_t'(V_ACTIVE);
  localparam cnt_t HS0 = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS1 = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS0 = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS1 = cnt_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam cnt_t PIC0 = cnt_t'(Y0);
  localparam cnt_t PIC1 = cnt_t'(Y0 + 2 * PIC_LINES);
  cnt_t hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  always_comb begin
    hcnt_d = (hcnt_q == H_LAST) ? '0 : hcnt_q + cnt_t'(1);
    vcnt_d = (hcnt_q != H_LAST) ? vcnt_q : (vcnt_q == V_LAST) ? '0 : vcnt_q + cnt_t'(1);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end
  always_comb begin
    visible = hcnt_q < HA && vcnt_q < VA;
    picture = visible && vcnt_q >= PIC0 && vcnt_q < PIC1;
    hsync_n = !(hcnt_q >= HS0 && hcnt_q < HS1);
    vsync_n = !(vcnt_q >= VS0 && vcnt_q < VS1);
    vblank_irq = hcnt_q == '0 && vcnt_q == VA;
  end
  assign hcnt = hcnt_q;
  assign vcnt = vcnt_q;
endmodule

// File: rtl/video_scanout.sv
// video_scanout: VGA scanout of a 2x-doubled 320x200 line buffer through the palette
// Ports: clk, reset (async, active-high); vline/start render request to the line
// renderer; linebuf_rdidx/linebuf_data line-buffer read; pal_idx/pal_rgb palette
// read; vga_r/g/b, vga_hsync/vga_vsync (active-low) pins; vblank_irq pulse.
module video_scanout #(
  parameter int H_ACTIVE = video_timing_pkg::H_ACTIVE,
  parameter int H_FP = video_timing_pkg::H_FP,
  parameter int H_SYNC = video_timing_pkg::H_SYNC,
  parameter int H_BP = video_timing_pkg::H_BP,
  parameter int V_ACTIVE = video_timing_pkg::V_ACTIVE,
  parameter int V_FP = video_timing_pkg::V_FP,
  parameter int V_SYNC = video_timing_pkg::V_SYNC,
  parameter int V_BP = video_timing_pkg::V_BP,
  parameter int Y0 = video_timing_pkg::Y0,
  parameter int PIC_LINES = video_timing_pkg::PIC_LINES
) (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  vline,
  output logic        start,
  output logic [8:0]  linebuf_rdidx,
  input  logic [5:0]  linebuf_data,
  output logic [5:0]  pal_idx,
  input  logic [11:0] pal_rgb,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vblank_irq
);
  import video_timing_pkg::*;
  localparam int L = PIXEL_LATENCY;
  localparam cnt_t H_PRE = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 2);
  localparam cnt_t REQ0 = cnt_t'(Y0 - 3);
  localparam cnt_t REQ1 = cnt_t'(Y0 - 3 + 2 * PIC_LINES);
  localparam cnt_t HA = cnt_t'(H_ACTIVE);
  if (Y0 < 3) begin : g_y0_too_small
    $error("video_scanout: Y0 must be at least 3");
  end
  if (Y0 + 2 * PIC_LINES > V_ACTIVE) begin : g_picture_too_tall
    $error("video_scanout: picture does not fit in the active lines");
  end
  cnt_t hcnt, vcnt;
  logic visible, picture, hsync_raw, vsync_raw;
  logic [8:0] req_off;
  logic start_d, start_q, picture_d, picture_q;
  logic [7:0] vline_d, vline_q;
  logic [L-2:0] visible_d, visible_q;
  logic [L-1:0] hsync_d, hsync_q, vsync_d, vsync_q;
  logic [11:0] rgb_d, rgb_q;
  video_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .Y0(Y0), .PIC_LINES(PIC_LINES)
  ) u_timing (
    .clk(clk), .reset(reset), .hcnt(hcnt), .vcnt(vcnt),
    .visible(visible), .picture(picture), .hsync_n(hsync_raw), .vsync_n(vsync_raw),
    .vblank_irq(vblank_irq)
  );
  // start is decoded one clock early so the registered pulse (and the matching
  // vline) sits on the last clock of the request line
  always_comb begin
    req_off = 9'(vcnt - REQ0);
    start_d = hcnt == H_PRE && vcnt >= REQ0 && vcnt <= REQ1 && !req_off[0];
    vline_d = start_d ? req_off[8:1] : vline_q;
    picture_d = picture;
    visible_d = {visible_q[L-3:0], visible};
    hsync_d = {hsync_q[L-2:0], hsync_raw};
    vsync_d = {vsync_q[L-2:0], vsync_raw};
    rgb_d = visible_q[L-2] ? pal_rgb : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q <= 1'b0;
      vline_q <= '0;
      picture_q <= 1'b0;
      visible_q <= '0;
      hsync_q <= '1;
      vsync_q <= '1;
      rgb_q <= '0;
    end else begin
      start_q <= start_d;
      vline_q <= vline_d;
      picture_q <= picture_d;
      visible_q <= visible_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q <= rgb_d;
    end
  end
  assign linebuf_rdidx = hcnt < HA ? hcnt[9:1] : '0;
  assign pal_idx = picture_q ? linebuf_data : '0;
  assign start = start_q;
  assign vline = vline_q;
  assign {vga_r, vga_g, vga_b} = rgb_q;
  assign vga_hsync = hsync_q[L-1];
  assign vga_vsync = vsync_q[L-1];
endmodule
